// File: rtl/fft_band_accumulator.sv
// Streams complex FFT bins, sums approximate magnitudes into 16 linear bands and publishes a frame.
// Optional macro BAND_PEAK_HOLD_EN: each band holds its peak and decays by 1/16 per frame.
module fft_band_accumulator #(
    parameter int N_BINS = 256,
    parameter int BIN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bin_valid,
    input  logic [BIN_W-1:0]  i_bin_re,
    input  logic [BIN_W-1:0]  i_bin_im,
    input  logic              i_bin_last,
    output logic [15:0][15:0] o_fft_data,
    output logic              o_fft_done,
    output logic              o_sync_err
);
    localparam int LOG2N = $clog2(N_BINS);
    localparam int LOG2B = LOG2N - 4;
    localparam int ACC_W = BIN_W + LOG2B;
    localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N_BINS - 1);

    typedef enum logic {S_RUN, S_RESYNC} state_t;

    // The most negative input has no positive twin, so it clamps to the largest positive value.
    function automatic logic [BIN_W-1:0] abs_sat(input logic [BIN_W-1:0] x);
        if (x == {1'b1, {(BIN_W-1){1'b0}}})
            return {1'b0, {(BIN_W-1){1'b1}}};
        else if (x[BIN_W-1])
            return -x;
        else
            return x;
    endfunction

    logic [BIN_W-1:0] abs_re, abs_im, mag;

    always_comb begin
        abs_re = abs_sat(i_bin_re);
        abs_im = abs_sat(i_bin_im);
        if (abs_re >= abs_im) mag = abs_re + (abs_im >> 1);
        else                  mag = abs_im + (abs_re >> 1);
    end

    // Stage 1: framing FSM, bin counter, registered magnitude and control flags.
    state_t           state_q, state_d;
    logic [LOG2N-1:0] bin_count_q, count_d;
    logic             add_d, complete_d, clear_d, err_d;
    logic             s1_add, s1_complete, s1_clear, s1_err;
    logic [BIN_W-1:0] s1_mag;
    logic [3:0]       s1_band;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        state_d    = state_q;
        count_d    = bin_count_q;
        add_d      = 1'b0;
        complete_d = 1'b0;
        clear_d    = 1'b0;
        err_d      = 1'b0;
        if (i_bin_valid) begin
            case (state_q)
                S_RUN: begin
                    if (bin_count_q == LAST_BIN) begin
                        count_d = '0;
                        if (i_bin_last) begin
                            add_d      = 1'b1;
                            complete_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            clear_d = 1'b1;
                            state_d = S_RESYNC;
                        end
                    end else if (i_bin_last) begin
                        err_d   = 1'b1;
                        clear_d = 1'b1;
                        count_d = '0;
                    end else begin
                        add_d   = 1'b1;
                        count_d = bin_count_q + LOG2N'(1);
                    end
                end
                S_RESYNC: begin
                    if (i_bin_last) begin
                        clear_d = 1'b1;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            state_q     <= S_RUN;
            bin_count_q <= '0;
            s1_add      <= 1'b0;
            s1_complete <= 1'b0;
            s1_clear    <= 1'b0;
            s1_err      <= 1'b0;
            s1_mag      <= '0;
            s1_band     <= '0;
        end else begin
            state_q     <= state_d;
            bin_count_q <= count_d;
            s1_add      <= add_d;
            s1_complete <= complete_d;
            s1_clear    <= clear_d;
            s1_err      <= err_d;
            s1_mag      <= mag;
            s1_band     <= bin_count_q[LOG2N-1:LOG2B];
        end
    end

    assign o_sync_err = s1_err;

    // Stage 2: band accumulators; on completion the final bin is folded into the published sums.
    logic [ACC_W-1:0] acc_q   [16];
    logic [ACC_W-1:0] acc_sum [16];
    logic [15:0]      band_out[16];
`ifdef BAND_PEAK_HOLD_EN
    logic [15:0]      band_new[16];
    logic [15:0]      decayed [16];
`endif

    always_comb begin
        for (int b = 0; b < 16; b++) begin
            acc_sum[b] = acc_q[b] + ((s1_add && s1_band == 4'(b)) ? ACC_W'(s1_mag) : '0);
`ifdef BAND_PEAK_HOLD_EN
            band_new[b] = 16'(acc_sum[b] >> LOG2B);
            decayed[b]  = o_fft_data[b] - (o_fft_data[b] >> 4);
            band_out[b] = (band_new[b] > decayed[b]) ? band_new[b] : decayed[b];
`else
            band_out[b] = 16'(acc_sum[b] >> LOG2B);
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: the accumulators are 16 discrete registers, not a RAM, so they reset like any flop.
        if (!i_rst_n) begin
            for (int b = 0; b < 16; b++) acc_q[b] <= '0;
            o_fft_data <= '0;
            o_fft_done <= 1'b0;
        end else begin
            o_fft_done <= s1_complete;
            if (s1_complete) begin
                for (int b = 0; b < 16; b++) begin
                    acc_q[b]      <= '0;
                    o_fft_data[b] <= band_out[b];
                end
            end else if (s1_clear) begin
                for (int b = 0; b < 16; b++) acc_q[b] <= '0;
            end else begin
                for (int b = 0; b < 16; b++) acc_q[b] <= acc_sum[b];
            end
        end
    end

endmodule

// File: tb/tb_fft_band_accumulator.sv
// Self-checking bench for fft_band_accumulator (N_BINS=256, BIN_W=16) against a frame-level model.
module tb_fft_band_accumulator;
    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_bin_valid = 1'b0;
    logic [15:0]       i_bin_re = '0;
    logic [15:0]       i_bin_im = '0;
    logic              i_bin_last = 1'b0;
    logic [15:0][15:0] o_fft_data;
    logic              o_fft_done;
    logic              o_sync_err;

    fft_band_accumulator #(.N_BINS(256), .BIN_W(16)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_bin_valid(i_bin_valid),
        .i_bin_re   (i_bin_re),
        .i_bin_im   (i_bin_im),
        .i_bin_last (i_bin_last),
        .o_fft_data (o_fft_data),
        .o_fft_done (o_fft_done),
        .o_sync_err (o_sync_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_drv = 0;
    int fr_re[256];
    int fr_im[256];
    logic [15:0][15:0] model_data = '0;
    logic [15:0][15:0] done_data_q[$];
    int done_cyc_q[$];
    int err_cyc_q[$];

    always @(posedge i_clk) cycle <= cycle + 1;

    always @(negedge i_clk) begin
        if (o_fft_done) begin
            done_data_q.push_back(o_fft_data);
            done_cyc_q.push_back(cycle);
        end
        if (o_sync_err) err_cyc_q.push_back(cycle);
    end

    // Reference model: magnitude of one bin and the whole-frame band result.
    function automatic int ref_mag(input int re, input int im);
        int ar, ai;
        ar = (re == -32768) ? 32767 : ((re < 0) ? -re : re);
        ai = (im == -32768) ? 32767 : ((im < 0) ? -im : im);
        return (ar > ai) ? ar + ai / 2 : ai + ar / 2;
    endfunction

    function automatic logic [15:0][15:0] model_complete();
        logic [15:0][15:0] r;
        for (int b = 0; b < 16; b++) begin
            int sum = 0;
            int nv;
            for (int k = 0; k < 16; k++) sum += ref_mag(fr_re[16*b+k], fr_im[16*b+k]);
            nv = sum / 16;
`ifdef BAND_PEAK_HOLD_EN
            begin
                int dec = int'(model_data[b]) - int'(model_data[b]) / 16;
                if (dec > nv) nv = dec;
            end
`endif
            r[b] = 16'(nv);
        end
        model_data = r;
        return r;
    endfunction

    task automatic fill_const(input int re, input int im);
        for (int i = 0; i < 256; i++) begin fr_re[i] = re; fr_im[i] = im; end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 15) == 0) fr_re[i] = -32768;
            if ($urandom_range(0, 15) == 0) fr_im[i] = -32768;
        end
    endtask

    task automatic idle(input int n);
        i_bin_valid = 1'b0;
        i_bin_last  = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input int nbins, input int last_at, input bit gaps);
        for (int i = 0; i < nbins; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_bin_valid = 1'b0;
                @(posedge i_clk);
                #1;
            end
            i_bin_valid = 1'b1;
            i_bin_re    = 16'(fr_re[i]);
            i_bin_im    = 16'(fr_im[i]);
            i_bin_last  = (i == last_at);
            last_drv    = cycle;
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        done_data_q.delete();
        done_cyc_q.delete();
        err_cyc_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_fft_data, o_fft_done, o_sync_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h done=%b err=%b want all zero", o_fft_data, o_fft_done, o_sync_err);
        end
        i_rst_n = 1'b1;
        idle(3);
        checks++;
        if (o_fft_data !== '0 || done_cyc_q.size() != 0 || err_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle got data=%h dones=%0d errs=%0d want 0/0/0", o_fft_data, done_cyc_q.size(), err_cyc_q.size());
        end
    endtask

    task automatic run_good_frame(input string name, input bit gaps);
        logic [15:0][15:0] exp_data;
        clear_queues();
        exp_data = model_complete();
        send_frame(256, 255, gaps);
        idle(6);
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_count got %0d want 1", name, done_cyc_q.size());
        end else begin
            checks++;
            if (done_cyc_q[0] != last_drv + 2) begin
                errors++;
                $display("FAIL %s done_latency got %0d want %0d", name, done_cyc_q[0] - last_drv, 2);
            end
            checks++;
            if (done_data_q[0] !== exp_data) begin
                errors++;
                $display("FAIL %s data got %h want %h", name, done_data_q[0], exp_data);
            end
        end
        checks++;
        if (err_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL %s spurious_sync_err got %0d want 0", name, err_cyc_q.size());
        end
    endtask

    task automatic test_constant();
        fill_const(100, 0);
        run_good_frame("constant_100", 1'b0);
    endtask

    task automatic test_magnitude();
        fill_const(3, 4);
        run_good_frame("mag_3_4", 1'b0);
        fill_const(-32768, -32768);
        run_good_frame("mag_most_negative", 1'b0);
    endtask

    task automatic test_band_mapping();
        fill_const(0, 0);
        fr_re[17] = 160;
        run_good_frame("band_map_bin17", 1'b1);
    endtask

    task automatic test_short_frame();
        logic [15:0][15:0] held;
        held = model_data;
        clear_queues();
        fill_random();
        send_frame(101, 100, 1'b0);
        idle(6);
        checks++;
        if (err_cyc_q.size() != 1 || err_cyc_q[0] != last_drv + 1) begin
            errors++;
            $display("FAIL short_sync_err got count=%0d want one pulse at +1", err_cyc_q.size());
        end
        checks++;
        if (done_cyc_q.size() != 0 || o_fft_data !== held) begin
            errors++;
            $display("FAIL short_discard got dones=%0d data=%h want 0 and %h", done_cyc_q.size(), o_fft_data, held);
        end
        fill_random();
        run_good_frame("after_short", 1'b1);
    endtask

    task automatic test_missing_last_b2b();
        logic [15:0][15:0] exp_a, exp_b;
        int last_a;
        clear_queues();
        fill_random();
        send_frame(256, -1, 1'b0);
        checks++;
        idle(3);
        if (err_cyc_q.size() != 1 || err_cyc_q[0] != last_drv + 1) begin
            errors++;
            $display("FAIL missing_last_sync_err got count=%0d want one pulse at +1", err_cyc_q.size());
        end
        clear_queues();
        send_frame(7, 6, 1'b1);
        idle(4);
        checks++;
        if (done_cyc_q.size() != 0 || err_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL resync_discard got dones=%0d errs=%0d want 0/0", done_cyc_q.size(), err_cyc_q.size());
        end
        fill_random();
        exp_a = model_complete();
        send_frame(256, 255, 1'b0);
        last_a = last_drv;
        fill_random();
        exp_b = model_complete();
        send_frame(256, 255, 1'b0);
        idle(6);
        checks++;
        if (done_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 2", done_cyc_q.size());
        end else begin
            checks++;
            if (done_cyc_q[0] != last_a + 2 || done_cyc_q[1] - done_cyc_q[0] != 256) begin
                errors++;
                $display("FAIL b2b_spacing got first=+%0d gap=%0d want +2 and 256", done_cyc_q[0] - last_a, done_cyc_q[1] - done_cyc_q[0]);
            end
            checks++;
            if (done_data_q[0] !== exp_a) begin
                errors++;
                $display("FAIL b2b_frame_a got %h want %h", done_data_q[0], exp_a);
            end
            checks++;
            if (done_data_q[1] !== exp_b) begin
                errors++;
                $display("FAIL b2b_frame_b got %h want %h", done_data_q[1], exp_b);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_good_frame($sformatf("random_%0d", f), 1'b1);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_random();
        send_frame(100, -1, 1'b1);
        i_rst_n = 1'b0;
        #2;
        checks++;
        if ({o_fft_data, o_fft_done, o_sync_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got data=%h done=%b err=%b want all zero", o_fft_data, o_fft_done, o_sync_err);
        end
        model_data = '0;
        idle(2);
        i_rst_n = 1'b1;
        idle(1);
        fill_random();
        run_good_frame("after_mid_reset", 1'b1);
    endtask

    task automatic test_peak_hold();
        fill_const(1600, 0);
        run_good_frame("peak_1600", 1'b0);
        fill_const(0, 0);
        run_good_frame("peak_then_zero", 1'b0);
`ifdef BAND_PEAK_HOLD_EN
        checks++;
        if (o_fft_data !== {16{16'd1500}}) begin
            errors++;
            $display("FAIL peak_decay got %h want all 05dc", o_fft_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_constant();
        test_magnitude();
        test_band_mapping();
        test_short_frame();
        test_missing_last_b2b();
        test_random();
        test_reset_mid_frame();
        test_peak_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_band_accumulator.md
# fft_band_accumulator

Converts the streaming complex FFT output into the 16-band, 16-bit-per-band magnitude frame consumed by the spectrum renderer. It sits directly upstream of the renderer:
- accepts one complex bin per valid cycle;
- computes an approximate magnitude;
- sums bins into 16 equal-width linear bands.

At frame end it publishes the whole frame at once, with a one-cycle done pulse.

## Interface
- `N_BINS`, default 256: bins per frame; must be a power of two ≥ 16.
- `BIN_W`, default 16: signed width of `i_bin_re` and `i_bin_im`.
- `i_clk`, input, 1: system clock.
- `i_rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `i_bin_valid`, input, 1: bin present this cycle. Always accepted; there is no backpressure.
- `i_bin_re`, input, `BIN_W`: real part, two's complement.
- `i_bin_im`, input, `BIN_W`: imaginary part, two's complement.
- `i_bin_last`, input, 1: marks the final bin of a frame. Qualified by `i_bin_valid`.
- `o_fft_data`, output, [15:0][15:0]: band magnitudes, unsigned. Index 0 is the lowest band. Held stable between done pulses.
- `o_fft_done`, output, 1: one-cycle pulse; `o_fft_data` is new in this cycle.
- `o_sync_err`, output, 1: one-cycle pulse on a frame-framing violation.

## Operation
- Bins per band: `B = N_BINS/16`. The band index is `bin_count[log2(N_BINS)-1 : log2(B)]`.
- Absolute value:
  - negative inputs are negated;
  - the most negative value saturates to `2^(BIN_W-1)-1`.
- Magnitude: `mag = max(|re|,|im|) + (min(|re|,|im|) >> 1)`. Unsigned, `BIN_W` bits; it cannot overflow.
- Accumulators: 16 of them, each `BIN_W + log2(B)` bits.
- Band output: `acc >> log2(B)`. This always fits in 16 bits for `BIN_W` = 16, so no saturation is needed.
- States:
  - **S_RUN**
    - Every valid bin increments `bin_count` and adds its magnitude to the band's accumulator.
    - A bin with `bin_count == N_BINS-1` and `i_bin_last`=1 completes the frame. All 16 outputs update, accumulators clear, `bin_count` returns to 0.
    - If `i_bin_last`=1 while `bin_count != N_BINS-1`, the frame is short: pulse `o_sync_err`, discard the frame, clear accumulators and `bin_count`, stay in S_RUN. The next bin starts a new frame.
    - If `bin_count == N_BINS-1` and `i_bin_last`=0, `i_bin_last` is missing: pulse `o_sync_err`, discard the frame, go to S_RESYNC.
  - **S_RESYNC**: discard valid bins until one arrives with `i_bin_last`=1 (that bin is discarded too). Then clear and return to S_RUN.
- Discarded frames produce no `o_fft_done`, and `o_fft_data` keeps its previous value.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the magnitude, band index, and frame-complete/error flags.
  - Stage 2 accumulates.
- A bin accepted at cycle t is in its accumulator at t+2.
- Frame completion, last bin accepted at cycle t:
  - `o_data` updates with the final bin included;
  - `o_fft_done`=1 at t+2, for exactly one cycle.
- `o_sync_err` asserts at t+1 after the offending bin is accepted.
- Frames may be back-to-back with zero gap: a first bin at t+1 lands in freshly cleared accumulators with no loss.
- Gaps in `i_bin_valid` are allowed anywhere and add no latency.
- Reset values:
  - `o_fft_data`=0, `o_fft_done`=0, `o_sync_err`=0;
  - state S_RUN, `bin_count`=0, accumulators 0, pipeline valid flags 0.
- An asynchronous reset mid-frame discards the partial frame. The first bin after reset release is bin 0.

## Configuration
- `BAND_PEAK_HOLD_EN`:
  - **Defined**: on frame completion, each band becomes `max(new, prev - (prev >> 4))`. This gives peak hold with a 1/16-per-frame decay.
  - **Undefined**: each band becomes `new` directly.
- Latency is the same in both cases.

## Test plan
All scenarios use `N_BINS`=256, so B=16.
- **Constant frame:** 256 bins with re=100, im=0, `last` on bin 255 → every band = 100; `o_fft_done` pulses 2 cycles after the last bin.
- **Magnitude corners:**
  - re=3, im=4 on all bins → all bands = 5.
  - re=im=-32768 → all bands = 49150.
- **Band mapping:** only bin 17 has re=160, all other bins are 0 → band 1 = 10, all other bands = 0.
- **Short frame:** `last` on bin 100 → `o_sync_err` pulse, no done, data unchanged; a following valid 256-bin frame completes normally.
- **Missing last, then back-to-back frames:**
  - Bin 255 arrives without `last` → `o_sync_err`, S_RESYNC.
  - Resync on a later `last`.
  - Two frames with no gap → two done pulses 256 cycles apart, with correct data.
- **Reset and peak hold:**
  - `i_rst_n` low mid-frame → outputs 0; the next full frame is correct.
  - With `BAND_PEAK_HOLD_EN`, a frame of 1600s followed by a frame of 0s → bands 1600, then 1500.
